// File: rtl/tl_pkg.sv
// Shared lamp encodings, state codes and helpers for the timed two-road
// traffic-light controller with left-turn phases.
package tl_pkg;

  localparam int unsigned LAMP_W  = 2;
  localparam int unsigned STATE_W = 3;

  localparam logic [LAMP_W-1:0] LAMP_GREEN  = 2'b00;
  localparam logic [LAMP_W-1:0] LAMP_YELLOW = 2'b01;
  localparam logic [LAMP_W-1:0] LAMP_LEFT   = 2'b10;
  localparam logic [LAMP_W-1:0] LAMP_RED    = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    ST_A_G  = 3'd0,
    ST_A_Y  = 3'd1,
    ST_A_L  = 3'd2,
    ST_A_LY = 3'd3,
    ST_B_G  = 3'd4,
    ST_B_Y  = 3'd5,
    ST_B_L  = 3'd6,
    ST_B_LY = 3'd7
  } tl_state_e;

  typedef struct packed {
    logic [LAMP_W-1:0] la;
    logic [LAMP_W-1:0] lb;
  } tl_lamps_t;

  function automatic int unsigned tl_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Moore lamp decode; any non-A state leaves road A at red and vice versa.
  function automatic tl_lamps_t tl_decode(input tl_state_e st);
    tl_lamps_t l;
    l.la = LAMP_RED;
    l.lb = LAMP_RED;
    case (st)
      ST_A_G:          l.la = LAMP_GREEN;
      ST_A_Y, ST_A_LY: l.la = LAMP_YELLOW;
      ST_A_L:          l.la = LAMP_LEFT;
      ST_B_G:          l.lb = LAMP_GREEN;
      ST_B_Y, ST_B_LY: l.lb = LAMP_YELLOW;
      ST_B_L:          l.lb = LAMP_LEFT;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Per-phase cycle counter: cleared on a phase change, otherwise counts up
// and saturates at all-ones.
module tl_phase_timer #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (!(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/tl_cntr_timed_left.sv
// Timed two-road traffic-light controller with left-turn phases. Lamps are
// registered from the next state, so no sensor reaches a lamp combinationally.
module tl_cntr_timed_left
  import tl_pkg::*;
#(
  parameter int unsigned GREEN_MIN     = 4,
  parameter int unsigned GREEN_MAX     = 16,
  parameter int unsigned LEFT_MIN      = 2,
  parameter int unsigned LEFT_MAX      = 8,
  parameter int unsigned YELLOW_CYCLES = 2,
  localparam int unsigned CNT_W =
    $clog2(tl_max(tl_max(tl_max(GREEN_MIN, GREEN_MAX), tl_max(LEFT_MIN, LEFT_MAX)),
                  YELLOW_CYCLES)) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Ta,
  input  logic               Tal,
  input  logic               Tb,
  input  logic               Tbl,
  output logic [LAMP_W-1:0]  La,
  output logic [LAMP_W-1:0]  Lb,
  output logic [STATE_W-1:0] phase,
  output logic [CNT_W-1:0]   phase_cnt
);

  localparam logic [CNT_W-1:0] GMIN_L = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_L = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] LMIN_L = CNT_W'(LEFT_MIN - 1);
  localparam logic [CNT_W-1:0] LMAX_L = CNT_W'(LEFT_MAX - 1);
  localparam logic [CNT_W-1:0] YEND_L = CNT_W'(YELLOW_CYCLES - 1);

  tl_state_e        state_q, state_d;
  tl_lamps_t        lamps_q, lamps_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr_c;

  tl_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr_c),
    .cnt  (cnt)
  );

  // Next-state: green/left exits are gated on minimum time and competing
  // demand; yellows run a fixed length and only look at the left sensor.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_A_G: begin
        if ((cnt >= GMIN_L) && (Tal | Tb | Tbl) && (!Ta || (cnt >= GMAX_L)))
          state_d = ST_A_Y;
      end
      ST_A_Y: begin
        if (cnt == YEND_L) state_d = Tal ? ST_A_L : ST_B_G;
      end
      ST_A_L: begin
        if ((cnt >= LMIN_L) && (!Tal || ((cnt >= LMAX_L) && (Ta | Tb | Tbl))))
          state_d = ST_A_LY;
      end
      ST_A_LY: begin
        if (cnt == YEND_L) state_d = ST_B_G;
      end
      ST_B_G: begin
        if ((cnt >= GMIN_L) && (Tbl | Ta | Tal) && (!Tb || (cnt >= GMAX_L)))
          state_d = ST_B_Y;
      end
      ST_B_Y: begin
        if (cnt == YEND_L) state_d = Tbl ? ST_B_L : ST_A_G;
      end
      ST_B_L: begin
        if ((cnt >= LMIN_L) && (!Tbl || ((cnt >= LMAX_L) && (Tb | Ta | Tal))))
          state_d = ST_B_LY;
      end
      ST_B_LY: begin
        if (cnt == YEND_L) state_d = ST_A_G;
      end
      default: state_d = ST_A_G;
    endcase
  end

  assign cnt_clr_c = (state_d != state_q);

  always_comb begin
    lamps_d = tl_decode(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_A_G;
      lamps_q.la <= LAMP_GREEN;
      lamps_q.lb <= LAMP_RED;
    end else begin
      state_q <= state_d;
      lamps_q <= lamps_d;
    end
  end

  assign La        = lamps_q.la;
  assign Lb        = lamps_q.lb;
  assign phase     = state_q;
  assign phase_cnt = cnt;

endmodule

// File: tb/tb_tl_cntr_timed_left.sv
// Directed-vector bench for tl_cntr_timed_left at default parameters.
module tb_tl_cntr_timed_left;

  logic       clk;
  logic       reset;
  logic       Ta, Tal, Tb, Tbl;
  logic [1:0] La, Lb;
  logic [2:0] phase;
  logic [4:0] phase_cnt;

  int vectors;
  int miscompares;

  tl_cntr_timed_left dut (
    .clk      (clk),
    .reset    (reset),
    .Ta       (Ta),
    .Tal      (Tal),
    .Tb       (Tb),
    .Tbl      (Tbl),
    .La       (La),
    .Lb       (Lb),
    .phase    (phase),
    .phase_cnt(phase_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample at the falling edge, and check lamp exclusivity.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    chk("safety", {7'b0, (La != 2'b11) && (Lb != 2'b11)}, 8'd0);
  endtask

  task automatic chk_st(input string tag, input logic [2:0] ph,
                        input logic [1:0] la, input logic [1:0] lb);
    chk({tag, "_phase"}, {5'b0, phase}, {5'b0, ph});
    chk({tag, "_lamps"}, {4'b0, La, Lb}, {4'b0, la, lb});
  endtask

  task automatic reset_with(input logic ta, input logic tal, input logic tb, input logic tbl);
    reset = 1'b1;
    Ta = ta; Tal = tal; Tb = tb; Tbl = tbl;
    step();
    reset = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    Ta = 1'b0; Tal = 1'b0; Tb = 1'b0; Tbl = 1'b0;
    @(negedge clk);

    // No demand: reset for 2 cycles, then A green holds forever.
    step();
    step();
    chk_st("rst", 3'd0, 2'b00, 2'b11);
    chk("rst_cnt", {3'b0, phase_cnt}, 8'd0);
    reset = 1'b0;
    repeat (30) step();
    chk_st("idle30", 3'd0, 2'b00, 2'b11);
    chk("idle30_cnt", {3'b0, phase_cnt}, 8'd30);

    // Only B demand: 4 green, 2 yellow, then B green.
    reset_with(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk_st("bdem_ag", 3'd0, 2'b00, 2'b11);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      chk_st("bdem_ay", 3'd1, 2'b01, 2'b11);
      step();
    end
    chk_st("bdem_bg", 3'd4, 2'b11, 2'b00);
    chk("bdem_bg_cnt", {3'b0, phase_cnt}, 8'd0);

    // Continuous A and B demand: greens last GREEN_MAX.
    reset_with(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk("max_ag", {5'b0, phase}, 8'd0);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      chk("max_ay", {5'b0, phase}, 8'd1);
      step();
    end
    for (int i = 0; i < 16; i++) begin
      chk("max_bg", {5'b0, phase}, 8'd4);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      chk("max_by", {5'b0, phase}, 8'd5);
      step();
    end
    chk_st("max_back_ag", 3'd0, 2'b00, 2'b11);

    // Left request arrives during A yellow, then drops after 3 left cycles.
    reset_with(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) step();
    chk("left_ay0", {5'b0, phase}, 8'd1);
    Tal = 1'b1;
    step();
    chk("left_ay1", {5'b0, phase}, 8'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      chk_st("left_al", 3'd2, 2'b10, 2'b11);
      chk("left_al_cnt", {3'b0, phase_cnt}, 8'(i));
      if (i < 2) step();
    end
    Tal = 1'b0;
    step();
    chk_st("left_aly0", 3'd3, 2'b01, 2'b11);
    step();
    chk_st("left_aly1", 3'd3, 2'b01, 2'b11);
    step();
    chk_st("left_bg", 3'd4, 2'b11, 2'b00);

    // Left held with Ta: left phase capped at LEFT_MAX.
    reset_with(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk("lmax_ag", {5'b0, phase}, 8'd0);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      chk("lmax_ay", {5'b0, phase}, 8'd1);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      chk("lmax_al", {5'b0, phase}, 8'd2);
      chk("lmax_al_cnt", {3'b0, phase_cnt}, 8'(i));
      step();
    end
    for (int i = 0; i < 2; i++) begin
      chk("lmax_aly", {5'b0, phase}, 8'd3);
      step();
    end
    chk_st("lmax_bg", 3'd4, 2'b11, 2'b00);

    // Reach B left, then reset at phase_cnt=3.
    reset_with(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (6) step();
    chk("bl_bg", {5'b0, phase}, 8'd4);
    Tb = 1'b0;
    Tbl = 1'b1;
    repeat (4) step();
    chk("bl_by", {5'b0, phase}, 8'd5);
    repeat (2) step();
    chk_st("bl_bl0", 3'd6, 2'b11, 2'b10);
    repeat (3) step();
    chk("bl_bl3", {5'b0, phase}, 8'd6);
    chk("bl_bl3_cnt", {3'b0, phase_cnt}, 8'd3);
    reset = 1'b1;
    step();
    chk_st("bl_rst", 3'd0, 2'b00, 2'b11);
    chk("bl_rst_cnt", {3'b0, phase_cnt}, 8'd0);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
